// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Arbitration mode encodings and index-width calculation live here.
package rr_mux_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   // Index width for n channels, never below 1 so a single-channel build keeps a real port.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed lowest-index priority.
// Searches a doubled request vector with bits below ptr masked, so wrap-around needs no second pass.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter  int NCH      = 4,
   parameter  int ARB_MODE = ARB_RR,
   localparam int SELW     = clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] grant_idx,
   output logic            any_grant
);

   logic [2*NCH-1:0] req_dbl;
   logic [SELW-1:0]  eff_ptr;
   logic             found;

   assign eff_ptr = (ARB_MODE == ARB_FIXED) ? '0 : ptr;
   assign req_dbl = {req, req};

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < 2*NCH; k++) begin
         if (!found && req_dbl[k] && (k >= int'(eff_ptr))) begin
            found = 1'b1;
            if (k >= NCH) begin
               grant[k-NCH] = 1'b1;
               grant_idx    = SELW'(k - NCH);
            end else begin
               grant[k]  = 1'b1;
               grant_idx = SELW'(k);
            end
         end
      end
   end

   assign any_grant = found;

endmodule

// File: rtl/rr_mux_stream.sv
// Merges NCH valid/ready input streams onto one registered output stream.
// One output register stage; a draining beat and a new beat can swap on the same edge.
module rr_mux_stream
   import rr_mux_pkg::*;
#(
   parameter  int WIDTH    = 5,
   parameter  int NCH      = 4,
   parameter  int ARB_MODE = ARB_RR,
   localparam int SELW     = clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   input  logic                 out_ready
);

   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  grant_idx;
   logic             any_grant;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;
   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  nxt_ptr;

   rr_arbiter #(
      .NCH      (NCH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Output register is free when empty or being drained this cycle.
   assign load_en  = ~out_valid | out_ready;
   assign in_ready = grant & {NCH{load_en & rst_n}};
   assign xfer     = any_grant & load_en;

   // AND-OR select over the one-hot grant, one channel slice per term.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      end
   end

   assign nxt_ptr = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
            if (ARB_MODE == ARB_RR) rr_ptr <= nxt_ptr;
         end else if (load_en) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed bench for rr_mux_stream: a round-robin instance driven from a vector table,
// and a fixed-priority instance with hand sequences, including reset during a stall.
module tb_rr_mux_stream;
   import rr_mux_pkg::*;

   localparam int W = 5;
   localparam int N = 4;

   logic           clk;
   logic           rst_n;

   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_sel;
   logic           out_ready;

   logic [N-1:0]   fx_valid;
   logic [N*W-1:0] fx_data;
   logic [N-1:0]   fx_in_ready;
   logic           fx_out_valid;
   logic [W-1:0]   fx_out_data;
   logic [1:0]     fx_out_sel;
   logic           fx_out_ready;

   int checks;
   int errors;

   logic [6:0] exp_q[$];

   rr_mux_stream #(.WIDTH(W), .NCH(N), .ARB_MODE(ARB_RR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   rr_mux_stream #(.WIDTH(W), .NCH(N), .ARB_MODE(ARB_FIXED)) dut_fx (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (fx_valid),
      .in_data   (fx_data),
      .in_ready  (fx_in_ready),
      .out_valid (fx_out_valid),
      .out_data  (fx_out_data),
      .out_sel   (fx_out_sel),
      .out_ready (fx_out_ready)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
      logic           rdy;
      logic [N-1:0]   ir;
      logic           ov;
      logic [W-1:0]   od;
      logic [1:0]     os;
      logic [1:0]     ptr;
   } vec_t;

   vec_t vecs[20];

   function automatic logic [N*W-1:0] pack(input logic [W-1:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic vec_t mk(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy,
                               input logic [N-1:0] ir, input logic ov, input logic [W-1:0] od,
                               input logic [1:0] os, input logic [1:0] ptr);
      vec_t r;
      r.v = v; r.d = d; r.rdy = rdy; r.ir = ir; r.ov = ov; r.od = od; r.os = os; r.ptr = ptr;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_rr(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
   endtask

   task automatic drive_fx(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy);
      fx_valid     = v;
      fx_data      = d;
      fx_out_ready = rdy;
   endtask

   // scoreboard: pops one expected {sel,data} for every beat the fixed instance delivers
   task automatic fx_monitor(input int step);
      logic [6:0] e;
      if (fx_out_valid && fx_out_ready) begin
         if (exp_q.size() == 0) begin
            check($sformatf("fx%0d unexpected_beat", step), 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("fx%0d beat", step), {25'd0, fx_out_sel, fx_out_data}, {25'd0, e});
         end
      end
   endtask

   logic [N-1:0] fx_ir_exp[6];

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive_rr('0, '0, 1'b1);
      drive_fx('0, '0, 1'b1);

      // fairness, single beat, wrap-around, backpressure
      vecs[0]  = mk(4'b1111, pack(5'h10, 5'h11, 5'h12, 5'h13), 1, 4'b0001, 0, 5'h00, 0, 0);
      vecs[1]  = mk(4'b1111, pack(5'h10, 5'h11, 5'h12, 5'h13), 1, 4'b0010, 1, 5'h10, 0, 1);
      vecs[2]  = mk(4'b1111, pack(5'h10, 5'h11, 5'h12, 5'h13), 1, 4'b0100, 1, 5'h11, 1, 2);
      vecs[3]  = mk(4'b1111, pack(5'h10, 5'h11, 5'h12, 5'h13), 1, 4'b1000, 1, 5'h12, 2, 3);
      vecs[4]  = mk(4'b1111, pack(5'h10, 5'h11, 5'h12, 5'h13), 1, 4'b0001, 1, 5'h13, 3, 0);
      vecs[5]  = mk(4'b1111, pack(5'h10, 5'h11, 5'h12, 5'h13), 1, 4'b0010, 1, 5'h10, 0, 1);
      vecs[6]  = mk(4'b0000, '0,                               1, 4'b0000, 1, 5'h11, 1, 2);
      vecs[7]  = mk(4'b0100, pack(5'h00, 5'h00, 5'h15, 5'h00), 1, 4'b0100, 0, 5'h11, 1, 2);
      vecs[8]  = mk(4'b0000, '0,                               1, 4'b0000, 1, 5'h15, 2, 3);
      vecs[9]  = mk(4'b1001, pack(5'h01, 5'h00, 5'h00, 5'h03), 1, 4'b1000, 0, 5'h15, 2, 3);
      vecs[10] = mk(4'b0001, pack(5'h01, 5'h00, 5'h00, 5'h03), 1, 4'b0001, 1, 5'h03, 3, 0);
      vecs[11] = mk(4'b0000, '0,                               1, 4'b0000, 1, 5'h01, 0, 1);
      vecs[12] = mk(4'b0010, pack(5'h00, 5'h0A, 5'h00, 5'h00), 0, 4'b0010, 0, 5'h01, 0, 1);
      vecs[13] = mk(4'b0001, pack(5'h07, 5'h00, 5'h00, 5'h00), 0, 4'b0000, 1, 5'h0A, 1, 2);
      vecs[14] = mk(4'b0001, pack(5'h07, 5'h00, 5'h00, 5'h00), 0, 4'b0000, 1, 5'h0A, 1, 2);
      vecs[15] = mk(4'b0001, pack(5'h07, 5'h00, 5'h00, 5'h00), 0, 4'b0000, 1, 5'h0A, 1, 2);
      vecs[16] = mk(4'b0001, pack(5'h07, 5'h00, 5'h00, 5'h00), 0, 4'b0000, 1, 5'h0A, 1, 2);
      vecs[17] = mk(4'b0001, pack(5'h07, 5'h00, 5'h00, 5'h00), 1, 4'b0001, 1, 5'h0A, 1, 2);
      vecs[18] = mk(4'b0000, '0,                               1, 4'b0000, 1, 5'h07, 0, 1);
      vecs[19] = mk(4'b0000, '0,                               0, 4'b0000, 0, 5'h07, 0, 1);

      // reset held three cycles; in_ready must stay low even with requests present
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 2) drive_rr(4'b1111, pack(5'h1, 5'h2, 5'h3, 5'h4), 1'b1);
         #1;
         check($sformatf("rst%0d in_ready", c), {28'd0, in_ready}, 32'd0);
         check($sformatf("rst%0d out_valid", c), {31'd0, out_valid}, 32'd0);
         check($sformatf("rst%0d out_data", c), {27'd0, out_data}, 32'd0);
         check($sformatf("rst%0d out_sel", c), {30'd0, out_sel}, 32'd0);
      end
      drive_rr('0, '0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 20; r++) begin
         @(negedge clk);
         drive_rr(vecs[r].v, vecs[r].d, vecs[r].rdy);
         #1;
         check($sformatf("row%0d in_ready", r), {28'd0, in_ready}, {28'd0, vecs[r].ir});
         check($sformatf("row%0d out_valid", r), {31'd0, out_valid}, {31'd0, vecs[r].ov});
         check($sformatf("row%0d out_data", r), {27'd0, out_data}, {27'd0, vecs[r].od});
         check($sformatf("row%0d out_sel", r), {30'd0, out_sel}, {30'd0, vecs[r].os});
         check($sformatf("row%0d rr_ptr", r), {30'd0, dut.rr_ptr}, {30'd0, vecs[r].ptr});
      end
      drive_rr('0, '0, 1'b1);

      // fixed priority: ch1 beats ch3 until ch1 drops
      exp_q.push_back({2'd1, 5'h05});
      exp_q.push_back({2'd1, 5'h05});
      exp_q.push_back({2'd1, 5'h05});
      exp_q.push_back({2'd1, 5'h05});
      exp_q.push_back({2'd3, 5'h09});
      fx_ir_exp[0] = 4'b0010; fx_ir_exp[1] = 4'b0010; fx_ir_exp[2] = 4'b0010;
      fx_ir_exp[3] = 4'b0010; fx_ir_exp[4] = 4'b1000; fx_ir_exp[5] = 4'b0000;
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         if (s < 4)       drive_fx(4'b1010, pack(5'h00, 5'h05, 5'h00, 5'h09), 1'b1);
         else if (s == 4) drive_fx(4'b1000, pack(5'h00, 5'h00, 5'h00, 5'h09), 1'b1);
         else             drive_fx(4'b0000, '0, 1'b1);
         #1;
         check($sformatf("fx%0d in_ready", s), {28'd0, fx_in_ready}, {28'd0, fx_ir_exp[s]});
         fx_monitor(s);
      end
      check("fx queue_drained", exp_q.size(), 32'd0);
      check("fx rr_ptr", {30'd0, dut_fx.rr_ptr}, 32'd0);
      check("fx out_valid_held", {31'd0, fx_out_valid}, 32'd1);

      // load a beat then stall; reset mid-stall must clear output before the next edge
      @(negedge clk);
      drive_rr(4'b0100, pack(5'h00, 5'h00, 5'h1F, 5'h00), 1'b0);
      #1;
      check("stall accept in_ready", {28'd0, in_ready}, 32'b0100);
      @(negedge clk);
      drive_rr('0, '0, 1'b0);
      #1;
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
      check("stall out_data", {27'd0, out_data}, 32'h1F);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async out_valid", {31'd0, out_valid}, 32'd0);
      check("async out_data", {27'd0, out_data}, 32'd0);
      check("async out_sel", {30'd0, out_sel}, 32'd0);
      check("async rr_ptr", {30'd0, dut.rr_ptr}, 32'd0);
      check("async fx out_valid", {31'd0, fx_out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_rr('0, '0, 1'b1);
      @(negedge clk);
      #1;
      check("post_rst out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst in_ready", {28'd0, in_ready}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_mux_stream.md
Name: rr_mux_stream

Overview:
- Parametrised successor to the team's gate-level 2:1 5-bit select mux.
- Merges NCH W-bit valid/ready input streams onto one registered output stream.
- Selection is by an internal arbiter (round-robin or fixed priority), not by an external select pin.
- Sits between the lab datapath producers and a shared single consumer, e.g. a display or result register.

Parameters:
- WIDTH, 5, data width per channel.
- NCH, 4, number of input channels (2..16).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with lowest index winning.
- SELW, clog2(NCH) (minimum 1), width of the channel-index output; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  NCH  per-channel request; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  one-hot (or zero) accept; combinational from grant.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_sel  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts when high with out_valid.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is 0 while reset is held.
- Single output register stage, so latency is 1 cycle from input acceptance to out_valid.
- load_en = ~out_valid | out_ready. An input beat can be accepted only when load_en=1.
- grant = arbiter(in_valid, rr_ptr), one-hot or zero. in_ready = grant & {NCH{load_en}}.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On the next edge: out_data<=data_i, out_sel<=i, out_valid<=1.
- If load_en=1 and no request is present: out_valid<=0, and out_data/out_sel hold their old values.
- While out_valid=1 and out_ready=0 (stall): out_valid, out_data and out_sel hold, and all in_ready are 0.
- Simultaneous drain and load (out_valid & out_ready & request): new beat loaded the same edge, no bubble. Throughput is 1 beat/cycle.
- Round-robin (ARB_MODE=0):
  - Search starts at rr_ptr and moves upward with wrap-around modulo NCH.
  - The first valid channel found wins.
  - After a transfer from channel i, rr_ptr <= (i+1) mod NCH, wrapping from NCH-1 to 0.
  - rr_ptr does not change if no transfer occurs.
- Fixed priority (ARB_MODE=1): lowest index with valid wins; rr_ptr is unused and stays 0.
- Channel requirement: a channel's in_valid and in_data must stay stable until accepted. The block does not check this.
- Grant is not sticky. A channel that drops valid before it is accepted loses its turn without error.
- NCH=1 degenerates to a registered pipe: out_sel is always 0 and SELW=1.
- Reset asserted mid-stall: the in-flight beat is discarded and out_valid falls immediately (async).
- Reset deassertion is expected to be synchronised externally. The first cycle after release behaves as empty.

Decomposition:
- Shared package rr_mux_pkg:
  - ARB_RR=0 and ARB_FIXED=1 constants.
  - clog2 function used for SELW.
- Sub-module rr_arbiter (params NCH, ARB_MODE):
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: one-hot grant[NCH], grant_idx[SELW], any_grant.
  - Purely combinational, using a double-width masked priority search.
- The top level holds the output register, rr_ptr, the load_en logic and the data select. The data select is an AND-OR over the one-hot grant, in the same style as the existing gate-level mux.

Test Plan:
- Reset then idle: rst_n low 3 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000 for every cycle.
- Single beat, WIDTH=5 NCH=4: ch2 valid with data 5'h15 for 1 cycle, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, out_data=5'h15, out_sel=2; rr_ptr becomes 3.
- Round-robin fairness: all 4 channels valid continuously (data = 5'h10+i), out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Wrap-around from a set pointer: rr_ptr=3 (after a ch2 beat), requests on ch0 and ch3 -> ch3 served first, then ch0; rr_ptr ends at 1.
- Backpressure: out_valid=1 holding 5'h0A from ch1, out_ready=0 for 4 cycles, ch0 valid -> out_data/out_sel hold 5'h0A/1 and in_ready=0000. out_ready rises -> the same edge loads ch0's beat.
- Fixed mode and reset mid-operation: ARB_MODE=1, ch1 and ch3 valid -> ch1 always wins and ch3 starves while ch1 stays valid. rst_n pulses low mid-stall -> out_valid drops to 0 asynchronously, before the next clock edge.
